load_unit_pipelined: RTL and testbench
======================================

Name: load_unit_pipelined

Overview:
Parametrised successor of the single-outstanding load unit. Accepts back-to-back loads, keeps up to DEPTH requests in flight to the data cache controller, and formats returned words in order (byte/half/word, signed/unsigned, any lane). Sits in the back-end execution stage between the issue stage and the writeback/reorder logic. Supports a flush that discards in-flight results without breaking cache ordering.

Parameters:
XLEN, 32, data/address width; 32 or 64 (64 adds LD/LWU lanes).
DEPTH, 4, max outstanding loads; power of 2, >= 2.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
valid_operation_i  in  1  load request valid
operation_i  in  ldu_operation_t  LB/LBU/LH/LHU/LW (LWU/LD when XLEN=64, FLW with FPU)
load_address_i  in  XLEN  byte address
instr_packet_i  in  instr_packet_t  issue packet
ready_o  out  1  request accepted this cycle when high with valid_operation_i
flush_i  in  1  kill all accepted, not-yet-returned loads
cache_ctrl_ready_i  in  1  cache controller can take a request
cache_ctrl_read_o  out  1  read request strobe
cache_ctrl_address_o  out  XLEN  word-aligned request address
cache_ctrl_cachable_o  out  1  address in a cachable region (memory map macros)
cache_ctrl_data_valid_i  in  1  in-order response valid
cache_ctrl_data_i  in  XLEN  response word
data_valid_o  out  1  formatted result valid (one-cycle pulse)
loaded_data_o  out  XLEN  formatted result
load_address_o  out  XLEN  original address of result
instr_packet_o  out  instr_packet_t  packet of result
idle_o  out  1  no entries outstanding, no result pending

Behaviour:
- Reset: queue empty (head=tail=0, count=0), data_valid_o=0, loaded_data_o=0, load_address_o=0, instr_packet_o=0, cache_ctrl_read_o=0, idle_o=1.
- ready_o = (count < DEPTH) & cache_ctrl_ready_i & !flush_i. No pop-bypass: a full queue keeps ready_o low even when a response pops that cycle.
- Accept: cache_ctrl_read_o = valid_operation_i & ready_o (combinational); cache_ctrl_address_o = load_address_i with low log2(XLEN/8) bits zeroed; push {operation, address, packet, killed=0} at tail.
- Response: cache_ctrl_data_valid_i pops the head. If head not killed, next cycle data_valid_o=1 with formatted data, head address and head packet. Killed heads pop silently.
- Formatting: byte lane = address[1:0] (address[2:0] for XLEN=64); half lane = address[1] (address[2:1]); sign- or zero-extend to XLEN. LW/FLW pass low 32 bits, sign-extended when XLEN=64.
- Latency: result 1 cycle after cache response; minimum accept-to-result = cache latency + 1. Throughput: one accept and one result per cycle.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- flush_i: sets killed on every valid entry in the same cycle; blocks accept; suppresses data_valid_o in the cycle after flush even when a response popped in the flush cycle. Entries stay queued until their responses arrive, preserving cache ordering.
- cache_ctrl_data_valid_i with empty queue: protocol error, response ignored, state unchanged. Bench asserts it never happens.
- idle_o = (count==0) & !data_valid_o.
- cache_ctrl_cachable_o decoded from load_address_i: INT_TABLE, EXT_NVM, INT_NVM and CODE regions.

Optional Feature:
LDU_MISALIGNED_CHECK_EN. Adds output misaligned_o (1 bit, reset 0).
- With it: a misaligned half/word/double load is never issued to the cache. It is accepted only when count==0 (otherwise ready_o stays low for it). Next cycle: data_valid_o=1, misaligned_o=1, loaded_data_o=0, with its address and packet.
- Without it: no alignment check. Lane selection uses only the defined address bits; the cache word is returned as-is.

Test Plan:
- Single LB at 0x1003, cache returns 0x80_00_00_00 two cycles later -> data_valid_o one cycle after response, loaded_data_o=0xFFFFFF80, cache_ctrl_address_o=0x1000.
- Four back-to-back loads (LW, LHU @+2, LBU @+1, LH @+0), DEPTH=4 -> fifth request sees ready_o=0. Responses return in order with correct extension, e.g. LHU of 0xBEEF_0000 at +2 gives 0x0000BEEF.
- Full queue with simultaneous response and new request -> request not accepted that cycle, accepted next cycle; count and pointer wrap verified.
- Three in flight, flush_i pulsed, then new LW accepted -> three responses produce no data_valid_o; fourth response yields the new LW result only.
- cache_ctrl_ready_i=0 for 5 cycles with valid_operation_i high -> no cache_ctrl_read_o, no push; idle_o stays 1.
- With LDU_MISALIGNED_CHECK_EN: LW at 0x2002 with queue empty -> no cache request, next cycle data_valid_o=1, misaligned_o=1, loaded_data_o=0. Same load with one entry in flight -> ready_o=0 until drained.

Source files
------------

// File: rtl/load_unit_pipelined.sv
// Pipelined load unit: up to DEPTH in-order loads outstanding to the data cache, results formatted in order.
// Optional misaligned-access trap enabled by defining LDU_MISALIGNED_CHECK_EN.

`ifndef MM_CODE_BASE
`define MM_CODE_BASE      32'h0000_1000
`define MM_CODE_END       32'h0000_FFFF
`define MM_INT_TABLE_BASE 32'h0001_0000
`define MM_INT_TABLE_END  32'h0001_03FF
`define MM_INT_NVM_BASE   32'h0002_0000
`define MM_INT_NVM_END    32'h0003_FFFF
`define MM_EXT_NVM_BASE   32'h2000_0000
`define MM_EXT_NVM_END    32'h3FFF_FFFF
`endif

package load_unit_pipelined_pkg;
    typedef enum logic [2:0] {
        LDU_LB, LDU_LBU, LDU_LH, LDU_LHU, LDU_LW, LDU_LWU, LDU_LD, LDU_FLW
    } ldu_operation_t;

    typedef struct packed {
        logic [5:0] rob_tag;
        logic [4:0] dest_reg;
    } instr_packet_t;
endpackage

module load_unit_pipelined
    import load_unit_pipelined_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_operation_i,
    input  ldu_operation_t  operation_i,
    input  logic [XLEN-1:0] load_address_i,
    input  instr_packet_t   instr_packet_i,
    output logic            ready_o,
    input  logic            flush_i,
    input  logic            cache_ctrl_ready_i,
    output logic            cache_ctrl_read_o,
    output logic [XLEN-1:0] cache_ctrl_address_o,
    output logic            cache_ctrl_cachable_o,
    input  logic            cache_ctrl_data_valid_i,
    input  logic [XLEN-1:0] cache_ctrl_data_i,
    output logic            data_valid_o,
    output logic [XLEN-1:0] loaded_data_o,
    output logic [XLEN-1:0] load_address_o,
    output instr_packet_t   instr_packet_o,
    output logic            idle_o
`ifdef LDU_MISALIGNED_CHECK_EN
    ,
    output logic            misaligned_o
`endif
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;
    ldu_operation_t   op_q   [DEPTH];
    logic [XLEN-1:0]  addr_q [DEPTH];
    instr_packet_t    pkt_q  [DEPTH];
    logic [DEPTH-1:0] killed_q;

    logic            push, pop, base_ready;
    logic [XLEN-1:0] fmt_data;

    function automatic logic in_region(input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] lo,
                                       input logic [XLEN-1:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic logic [XLEN-1:0] format_word(input ldu_operation_t op,
                                                    input logic [OFF_W-1:0] lane,
                                                    input logic [XLEN-1:0] w);
        logic [XLEN-1:0] b_sh, h_sh;
        b_sh = w >> {lane, 3'b000};
        h_sh = w >> {lane[OFF_W-1:1], 4'b0000};
        case (op)
            LDU_LB:  return XLEN'($signed(b_sh[7:0]));
            LDU_LBU: return XLEN'(b_sh[7:0]);
            LDU_LH:  return XLEN'($signed(h_sh[15:0]));
            LDU_LHU: return XLEN'(h_sh[15:0]);
            LDU_LWU: return XLEN'(w[31:0]);
            LDU_LD:  return w;
            default: return XLEN'($signed(w[31:0]));
        endcase
    endfunction

    assign base_ready = (count_q != FULL) & cache_ctrl_ready_i & !flush_i;
    assign pop        = cache_ctrl_data_valid_i & (count_q != '0);

    assign cache_ctrl_address_o  = {load_address_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign cache_ctrl_cachable_o =
        in_region(load_address_i, XLEN'(`MM_CODE_BASE),      XLEN'(`MM_CODE_END))      |
        in_region(load_address_i, XLEN'(`MM_INT_TABLE_BASE), XLEN'(`MM_INT_TABLE_END)) |
        in_region(load_address_i, XLEN'(`MM_INT_NVM_BASE),   XLEN'(`MM_INT_NVM_END))   |
        in_region(load_address_i, XLEN'(`MM_EXT_NVM_BASE),   XLEN'(`MM_EXT_NVM_END));

`ifdef LDU_MISALIGNED_CHECK_EN
    logic req_misaligned, mis_accept;

    always_comb begin
        req_misaligned = 1'b0;
        case (operation_i)
            LDU_LH, LDU_LHU:          req_misaligned = load_address_i[0];
            LDU_LW, LDU_LWU, LDU_FLW: req_misaligned = |load_address_i[1:0];
            LDU_LD:                   req_misaligned = |load_address_i[OFF_W-1:0];
            default:                  req_misaligned = 1'b0;
        endcase
    end

    // A trapped load never reaches the cache, so it only waits for the queue to drain.
    assign ready_o           = req_misaligned ? ((count_q == '0) & !flush_i) : base_ready;
    assign cache_ctrl_read_o = valid_operation_i & ready_o & !req_misaligned;
    assign mis_accept        = valid_operation_i & ready_o & req_misaligned;
`else
    assign ready_o           = base_ready;
    assign cache_ctrl_read_o = valid_operation_i & ready_o;
`endif

    assign push = cache_ctrl_read_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            killed_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Bits of empty slots are don't-care; a push always clears its own slot.
            if (flush_i)   killed_q         <= '1;
            else if (push) killed_q[tail_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            op_q[tail_q]   <= operation_i;
            addr_q[tail_q] <= load_address_i;
            pkt_q[tail_q]  <= instr_packet_i;
        end
    end

    assign fmt_data = format_word(op_q[head_q], addr_q[head_q][OFF_W-1:0], cache_ctrl_data_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_valid_o   <= 1'b0;
            loaded_data_o  <= '0;
            load_address_o <= '0;
            instr_packet_o <= '0;
`ifdef LDU_MISALIGNED_CHECK_EN
            misaligned_o   <= 1'b0;
`endif
        end else begin
            data_valid_o <= 1'b0;
`ifdef LDU_MISALIGNED_CHECK_EN
            misaligned_o <= 1'b0;
            if (mis_accept) begin
                data_valid_o   <= 1'b1;
                misaligned_o   <= 1'b1;
                loaded_data_o  <= '0;
                load_address_o <= load_address_i;
                instr_packet_o <= instr_packet_i;
            end else
`endif
            if (pop && !killed_q[head_q] && !flush_i) begin
                data_valid_o   <= 1'b1;
                loaded_data_o  <= fmt_data;
                load_address_o <= addr_q[head_q];
                instr_packet_o <= pkt_q[head_q];
            end
        end
    end

    assign idle_o = (count_q == '0) & !data_valid_o;

endmodule

// File: tb/tb_load_unit_pipelined.sv
// Directed bench for load_unit_pipelined: hand-computed expected results queued at issue,
// compared in order as the unit produces them.
module tb_load_unit_pipelined;
    import load_unit_pipelined_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int PW    = $bits(instr_packet_t);
    localparam int W     = 2 * XLEN + PW + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_operation;
    ldu_operation_t  operation;
    logic [XLEN-1:0] load_address;
    instr_packet_t   instr_packet_in;
    logic            ready_o;
    logic            flush;
    logic            cache_ctrl_ready;
    logic            cache_ctrl_read_o;
    logic [XLEN-1:0] cache_ctrl_address_o;
    logic            cache_ctrl_cachable_o;
    logic            cache_ctrl_data_valid;
    logic [XLEN-1:0] cache_ctrl_data;
    logic            data_valid_o;
    logic [XLEN-1:0] loaded_data_o;
    logic [XLEN-1:0] load_address_o;
    instr_packet_t   instr_packet_o;
    logic            idle_o;
`ifdef LDU_MISALIGNED_CHECK_EN
    logic            misaligned_o;
`endif

    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int results = 0;
    int expected_results = 0;
    int outstanding = 0;

    load_unit_pipelined #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i                   (clk),
        .rst_n_i                 (rst_n),
        .valid_operation_i       (valid_operation),
        .operation_i             (operation),
        .load_address_i          (load_address),
        .instr_packet_i          (instr_packet_in),
        .ready_o                 (ready_o),
        .flush_i                 (flush),
        .cache_ctrl_ready_i      (cache_ctrl_ready),
        .cache_ctrl_read_o       (cache_ctrl_read_o),
        .cache_ctrl_address_o    (cache_ctrl_address_o),
        .cache_ctrl_cachable_o   (cache_ctrl_cachable_o),
        .cache_ctrl_data_valid_i (cache_ctrl_data_valid),
        .cache_ctrl_data_i       (cache_ctrl_data),
        .data_valid_o            (data_valid_o),
        .loaded_data_o           (loaded_data_o),
        .load_address_o          (load_address_o),
        .instr_packet_o          (instr_packet_o),
        .idle_o                  (idle_o)
`ifdef LDU_MISALIGNED_CHECK_EN
        ,
        .misaligned_o            (misaligned_o)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_packet_t mkpkt(input int n);
        return instr_packet_t'(PW'(n * 37 + 5));
    endfunction

    // driver tasks
    task automatic req(input ldu_operation_t op, input logic [31:0] a, input int n);
        valid_operation = 1'b1;
        operation       = op;
        load_address    = a;
        instr_packet_in = mkpkt(n);
    endtask

    task automatic no_req();
        valid_operation = 1'b0;
    endtask

    task automatic respond(input logic [31:0] w);
        assert (outstanding > 0) else $fatal(1, "FAIL protocol observed=response expected=outstanding_load");
        outstanding--;
        cache_ctrl_data_valid = 1'b1;
        cache_ctrl_data       = w;
    endtask

    task automatic no_resp();
        cache_ctrl_data_valid = 1'b0;
        cache_ctrl_data       = '0;
    endtask

    task automatic expect_result(input logic [31:0] d, input logic [31:0] a, input int n,
                                 input logic mis);
        exp_q.push_back({d, a, mkpkt(n), mis});
        expected_results++;
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && data_valid_o === 1'b1) begin
            logic [W-1:0] e;
            results++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_result observed=%0h expected=none", loaded_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("result_data", 64'(loaded_data_o),  64'(e[W-1 -: XLEN]));
                chk("result_addr", 64'(load_address_o), 64'(e[XLEN+PW -: XLEN]));
                chk("result_pkt",  64'(instr_packet_o), 64'(e[PW:1]));
`ifdef LDU_MISALIGNED_CHECK_EN
                chk("result_mis",  64'(misaligned_o),   64'(e[0]));
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        no_req();
        operation       = LDU_LB;
        load_address    = '0;
        instr_packet_in = '0;
        flush           = 1'b0;
        cache_ctrl_ready = 1'b1;
        no_resp();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_data_valid", 64'(data_valid_o),      64'd0);
        chk("rst_loaded",     64'(loaded_data_o),     64'd0);
        chk("rst_addr",       64'(load_address_o),    64'd0);
        chk("rst_pkt",        64'(instr_packet_o),    64'd0);
        chk("rst_read",       64'(cache_ctrl_read_o), 64'd0);
        chk("rst_idle",       64'(idle_o),            64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // single LB, response two cycles later
        @(negedge clk);
        req(LDU_LB, 32'h1003, 1);
        #1;
        chk("t1_ready", 64'(ready_o),               64'd1);
        chk("t1_read",  64'(cache_ctrl_read_o),     64'd1);
        chk("t1_caddr", 64'(cache_ctrl_address_o),  64'h1000);
        chk("t1_cach",  64'(cache_ctrl_cachable_o), 64'd1);
        expect_result(32'hFFFF_FF80, 32'h1003, 1, 1'b0);
        outstanding++;
        @(negedge clk);
        no_req();
        #1 chk("t1_busy", 64'(idle_o), 64'd0);
        @(negedge clk);
        respond(32'h8000_0000);
        @(negedge clk);
        no_resp();
        #1 chk("t1_latency", 64'(data_valid_o), 64'd1);
        @(negedge clk);
        #1;
        chk("t1_pulse", 64'(data_valid_o), 64'd0);
        chk("t1_idle",  64'(idle_o),       64'd1);

        // four back-to-back loads fill the queue
        @(negedge clk); req(LDU_LW,  32'h1100, 2); #1;
        chk("t2_rd0", 64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'h1234_5678, 32'h1100, 2, 1'b0); outstanding++;
        @(negedge clk); req(LDU_LHU, 32'h1102, 3); #1;
        chk("t2_rd1", 64'(cache_ctrl_read_o), 64'd1);
        chk("t2_caddr1", 64'(cache_ctrl_address_o), 64'h1100);
        expect_result(32'h0000_BEEF, 32'h1102, 3, 1'b0); outstanding++;
        @(negedge clk); req(LDU_LBU, 32'h1101, 4); #1;
        chk("t2_rd2", 64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'h0000_00A5, 32'h1101, 4, 1'b0); outstanding++;
        @(negedge clk); req(LDU_LH,  32'h1100, 5); #1;
        chk("t2_rd3", 64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'hFFFF_8001, 32'h1100, 5, 1'b0); outstanding++;
        @(negedge clk); req(LDU_LW,  32'h1104, 6); #1;
        chk("t2_full_ready", 64'(ready_o),           64'd0);
        chk("t2_full_read",  64'(cache_ctrl_read_o), 64'd0);

        // full queue: a popping response does not open the door in the same cycle
        @(negedge clk); respond(32'h1234_5678); #1;
        chk("t3_nobypass_ready", 64'(ready_o),           64'd0);
        chk("t3_nobypass_read",  64'(cache_ctrl_read_o), 64'd0);
        @(negedge clk); respond(32'hBEEF_0000); #1;
        chk("t3_accept_ready", 64'(ready_o),           64'd1);
        chk("t3_accept_read",  64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'hCAFE_F00D, 32'h1104, 6, 1'b0); outstanding++;
        @(negedge clk); no_req(); respond(32'h0000_A500);
        @(negedge clk); respond(32'h0000_8001);
        @(negedge clk); respond(32'hCAFE_F00D);
        @(negedge clk); no_resp();
        @(negedge clk); #1 chk("t3_idle", 64'(idle_o), 64'd1);

        // flush with three in flight, response popping in the flush cycle
        @(negedge clk); req(LDU_LB, 32'h1200, 7); #1 chk("t4_rd0", 64'(cache_ctrl_read_o), 64'd1); outstanding++;
        @(negedge clk); req(LDU_LH, 32'h1202, 8); #1 chk("t4_rd1", 64'(cache_ctrl_read_o), 64'd1); outstanding++;
        @(negedge clk); req(LDU_LW, 32'h1204, 9); #1 chk("t4_rd2", 64'(cache_ctrl_read_o), 64'd1); outstanding++;
        @(negedge clk);
        flush = 1'b1;
        req(LDU_LW, 32'h1300, 10);
        respond(32'h1111_1111);
        #1;
        chk("t4_flush_ready", 64'(ready_o),           64'd0);
        chk("t4_flush_read",  64'(cache_ctrl_read_o), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        respond(32'h2222_2222);
        #1;
        chk("t4_flushcyc_suppressed", 64'(data_valid_o),      64'd0);
        chk("t4_new_read",            64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'h1122_3344, 32'h1300, 10, 1'b0); outstanding++;
        @(negedge clk); no_req(); respond(32'h3333_3333);
        #1 chk("t4_killed1", 64'(data_valid_o), 64'd0);
        @(negedge clk); respond(32'h1122_3344);
        #1 chk("t4_killed2", 64'(data_valid_o), 64'd0);
        @(negedge clk); no_resp();
        #1 chk("t4_new_result", 64'(data_valid_o), 64'd1);
        @(negedge clk); #1 chk("t4_idle", 64'(idle_o), 64'd1);

        // cache not ready: nothing issued, unit stays idle
        cache_ctrl_ready = 1'b0;
        req(LDU_LB, 32'h8000_0000, 11);
        #1 chk("t5_uncachable", 64'(cache_ctrl_cachable_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("t5_ready", 64'(ready_o),           64'd0);
            chk("t5_read",  64'(cache_ctrl_read_o), 64'd0);
            chk("t5_idle",  64'(idle_o),            64'd1);
        end
        @(negedge clk);
        no_req();
        cache_ctrl_ready = 1'b1;

        // upper lanes, back-to-back responses
        @(negedge clk); req(LDU_LBU, 32'h1007, 12); #1 chk("t6_rd0", 64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'h0000_00F1, 32'h1007, 12, 1'b0); outstanding++;
        @(negedge clk); req(LDU_LH,  32'h1006, 13); #1 chk("t6_rd1", 64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'hFFFF_8765, 32'h1006, 13, 1'b0); outstanding++;
        @(negedge clk); req(LDU_LB,  32'h1001, 14); #1 chk("t6_rd2", 64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'h0000_007F, 32'h1001, 14, 1'b0); outstanding++;
        @(negedge clk); no_req(); respond(32'hF100_0000);
        @(negedge clk); respond(32'h8765_4321);
        @(negedge clk); respond(32'h0000_7F00);
        @(negedge clk); no_resp();
        @(negedge clk); @(negedge clk); #1 chk("t6_idle", 64'(idle_o), 64'd1);

`ifdef LDU_MISALIGNED_CHECK_EN
        // misaligned trap with empty queue
        @(negedge clk); req(LDU_LW, 32'h2002, 20); #1;
        chk("m1_ready", 64'(ready_o),           64'd1);
        chk("m1_read",  64'(cache_ctrl_read_o), 64'd0);
        expect_result(32'h0, 32'h2002, 20, 1'b1);
        @(negedge clk); no_req(); #1 chk("m1_valid", 64'(data_valid_o), 64'd1);
        // misaligned load waits for the in-flight entry to drain
        @(negedge clk); req(LDU_LW, 32'h2000, 21); #1 chk("m2_rd", 64'(cache_ctrl_read_o), 64'd1);
        expect_result(32'hAAAA_5555, 32'h2000, 21, 1'b0); outstanding++;
        @(negedge clk); req(LDU_LW, 32'h2002, 22); #1;
        chk("m2_blocked_ready", 64'(ready_o),           64'd0);
        chk("m2_blocked_read",  64'(cache_ctrl_read_o), 64'd0);
        @(negedge clk); respond(32'hAAAA_5555); #1 chk("m2_still_blocked", 64'(ready_o), 64'd0);
        @(negedge clk); no_resp(); #1;
        chk("m2_drained_ready", 64'(ready_o),           64'd1);
        chk("m2_drained_read",  64'(cache_ctrl_read_o), 64'd0);
        expect_result(32'h0, 32'h2002, 22, 1'b1);
        @(negedge clk); no_req();
        @(negedge clk); @(negedge clk); #1 chk("m2_idle", 64'(idle_o), 64'd1);
`endif

        // final report
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("result_count",  64'(results),      64'(expected_results));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
